// File: rtl/display_mux_scheduler.sv
// display_mux_scheduler: two-digit display time-multiplexer with blanking between digit slots.
// Sequence is SHOW0 -> BLANK0 -> SHOW1 -> BLANK1; sel switches only on entry to a blanking slot.
module display_mux_scheduler #(
    parameter int REFRESH_CYCLES = 24000,
    parameter int BLANK_CYCLES   = 480,
    localparam int MAX_DWELL     = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES,
    localparam int CNT_W         = $clog2(MAX_DWELL + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] digit_en,
    output logic       sel,
    output logic [1:0] anode,
    output logic       frame_tick
);
    typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLANK1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        last    = cnt_q == ((state_q == SHOW0 || state_q == SHOW1) ? CNT_W'(REFRESH_CYCLES - 1)
                                                                    : CNT_W'(BLANK_CYCLES - 1));
        state_d = last ? state_t'(state_q + 2'd1) : state_q;
        cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
    end

    // Anodes stay dark in both blanking states so the segment bus settles before the next digit.
    always_comb begin
        sel        = state_q == BLANK0 || state_q == SHOW1;
        anode      = state_q == SHOW0 ? {1'b1, ~digit_en[0]} :
                     state_q == SHOW1 ? {~digit_en[1], 1'b1} : 2'b11;
        frame_tick = state_q == BLANK1 && last;
    end
endmodule

// File: tb/tb_display_mux_scheduler.sv
// tb_display_mux_scheduler: table vectors, random digit_en against an arithmetic frame-phase
// model, and hand-written reset, single-digit and period sequences.
module tb_display_mux_scheduler;
    localparam int R = 4;
    localparam int B = 2;
    localparam int P = 2 * (R + B);

    typedef struct {
        logic [1:0] en;
        logic       sel;
        logic [1:0] anode;
        logic       tick;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] digit_en = 2'b11;
    logic       sel;
    logic [1:0] anode;
    logic       frame_tick;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         k = 0;
    vec_t       vec [14];

    always #5 clk = ~clk;

    display_mux_scheduler #(.REFRESH_CYCLES(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .digit_en(digit_en),
        .sel(sel), .anode(anode), .frame_tick(frame_tick)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    // k counts edges since reset release; frame phase 0 is the first SHOW0 cycle.
    task automatic model(input int kk, input logic [1:0] en,
                         output logic s, output logic [1:0] a, output logic t);
        int ph;
        ph = (kk + P - B) % P;
        s  = (ph >= R) && (ph < 2 * R + B);
        a  = 2'b11;
        if (ph < R) a[0] = ~en[0];
        else if (ph >= R + B && ph < 2 * R + B) a[1] = ~en[1];
        t  = ph == P - 1;
    endtask

    task automatic check_model(input string tag);
        logic s, t;
        logic [1:0] a;
        model(k, digit_en, s, a, t);
        chk({tag, "_sel"}, 8'(sel), 8'(s));
        chk({tag, "_anode"}, 8'(anode), 8'(a));
        chk({tag, "_tick"}, 8'(frame_tick), 8'(t));
    endtask

    task automatic step;
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic release_reset;
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        #1;
    endtask

    task automatic run_table;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) step();
            digit_en = vec[i].en;
            #1;
            chk("tbl_sel", 8'(sel), 8'(vec[i].sel));
            chk("tbl_anode", 8'(anode), 8'(vec[i].anode));
            chk("tbl_tick", 8'(frame_tick), 8'(vec[i].tick));
        end
    endtask

    initial begin
        vec[0]  = '{2'b11, 1'b0, 2'b11, 1'b0};
        vec[1]  = '{2'b11, 1'b0, 2'b11, 1'b1};
        vec[2]  = '{2'b11, 1'b0, 2'b10, 1'b0};
        vec[3]  = '{2'b11, 1'b0, 2'b10, 1'b0};
        vec[4]  = '{2'b11, 1'b0, 2'b10, 1'b0};
        vec[5]  = '{2'b11, 1'b0, 2'b10, 1'b0};
        vec[6]  = '{2'b11, 1'b1, 2'b11, 1'b0};
        vec[7]  = '{2'b11, 1'b1, 2'b11, 1'b0};
        vec[8]  = '{2'b11, 1'b1, 2'b01, 1'b0};
        vec[9]  = '{2'b11, 1'b1, 2'b01, 1'b0};
        vec[10] = '{2'b11, 1'b1, 2'b01, 1'b0};
        vec[11] = '{2'b11, 1'b1, 2'b01, 1'b0};
        vec[12] = '{2'b11, 1'b0, 2'b11, 1'b0};
        vec[13] = '{2'b11, 1'b0, 2'b11, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_anode", 8'(anode), 8'h3);
        chk("rst_sel", 8'(sel), 8'h0);
        chk("rst_tick", 8'(frame_tick), 8'h0);
        release_reset();
        run_table();

        begin : random_frames
            logic prev_sel;
            prev_sel = sel;
            for (int c = 0; c < 100 * P; c++) begin
                step();
                digit_en = 2'($urandom);
                #1;
                check_model("rnd");
                chk("rnd_not_both_on", 8'(anode == 2'b00), 8'h0);
                if (sel !== prev_sel) chk("rnd_settle", 8'(anode), 8'h3);
                prev_sel = sel;
            end
        end

        begin : digit0_only
            digit_en = 2'b01;
            for (int f = 0; f < 3; f++) begin
                int lo0, lo1, ticks;
                lo0 = 0; lo1 = 0; ticks = 0;
                for (int c = 0; c < P; c++) begin
                    step();
                    check_model("en01");
                    lo0 += int'(!anode[0]);
                    lo1 += int'(!anode[1]);
                    ticks += int'(frame_tick);
                end
                chk("en01_on_cycles", 8'(lo0), 8'd4);
                chk("en01_digit1_dark", 8'(lo1), 8'd0);
                chk("en01_ticks", 8'(ticks), 8'd1);
            end
        end

        begin : all_off
            digit_en = 2'b00;
            for (int f = 0; f < 2; f++) begin
                int ticks, toggles;
                logic ps;
                ticks = 0; toggles = 0; ps = sel;
                for (int c = 0; c < P; c++) begin
                    step();
                    check_model("en00");
                    chk("en00_anode", 8'(anode), 8'h3);
                    ticks += int'(frame_tick);
                    toggles += int'(sel != ps);
                    ps = sel;
                end
                chk("en00_ticks", 8'(ticks), 8'd1);
                chk("en00_sel_toggles", 8'(toggles), 8'd2);
            end
        end

        begin : mid_slot_reset
            digit_en = 2'b11;
            release_reset();
            repeat (9) step();
            #1;
            chk("pre_rst_anode", 8'(anode), 8'h1);
            reset = 1'b1;
            #1;
            chk("async_rst_anode", 8'(anode), 8'h3);
            chk("async_rst_sel", 8'(sel), 8'h0);
            chk("async_rst_tick", 8'(frame_tick), 8'h0);
            @(posedge clk);
            release_reset();
            run_table();
        end

        begin : period
            int last, got;
            last = -1; got = 0;
            for (int c = 0; c < 12 * P && got < 11; c++) begin
                step();
                if (frame_tick) begin
                    if (last >= 0) chk("period", 8'(k - last), 8'(P));
                    last = k;
                    got++;
                end
            end
            chk("period_ticks_seen", 8'(got), 8'd11);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
